// File: rtl/pe_layer_sched.sv
// Timestep sequencer for a row of spiking PEs: takes one input spike vector per step,
// streams the weight row of every active input into the PEs, then collects the PE spikes.
`timescale 1ns/1ps
module pe_layer_sched #(
    parameter int N_PE     = 4,
    parameter int N_IN     = 8,
    parameter int WEIGHT_W = 8,
    parameter int STEP_W   = 8,
    localparam int ADDR_W  = $clog2(N_IN),
    localparam int IDX_W   = ADDR_W + 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [STEP_W-1:0]          num_steps,
    output logic                       busy,
    output logic                       done,
    input  logic [N_IN-1:0]            in_spikes,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       wmem_rd_en,
    output logic [ADDR_W-1:0]          wmem_addr,
    input  logic [N_PE*WEIGHT_W-1:0]   wmem_rdata,
    output logic [N_PE*WEIGHT_W-1:0]   pe_weight,
    output logic                       pe_weight_w_en,
    output logic                       pe_accum_en,
    output logic                       pe_spike_done,
    input  logic [N_PE-1:0]            pe_spike,
    output logic [N_PE-1:0]            out_spikes,
    output logic                       out_valid,
    input  logic                       out_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_SCAN    = 3'd2,
        S_LOAD    = 3'd3,
        S_ACCUM   = 3'd4,
        S_FIRE    = 3'd5,
        S_CAPTURE = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [IDX_W-1:0]    idx_r;
    logic [N_IN-1:0]     spike_reg_r;
    logic [STEP_W-1:0]   step_cnt_r;
    logic [STEP_W-1:0]   num_steps_r;
    logic [N_PE-1:0]     out_spikes_r;
    logic                out_valid_r;
    logic                done_r;

    logic                idx_end_s;
    logic                cur_bit_s;
    logic                rd_en_s;
    logic                last_step_s;

    assign idx_end_s   = (idx_r == IDX_W'(N_IN));
    assign cur_bit_s   = spike_reg_r[idx_r[ADDR_W-1:0]];
    assign rd_en_s     = (state_r == S_SCAN) && !idx_end_s && cur_bit_s;
    // One extra bit so num_steps = 2^STEP_W-1 compares without wrap.
    assign last_step_s = ({1'b0, step_cnt_r} + {{STEP_W{1'b0}}, 1'b1}) == {1'b0, num_steps_r};

    assign busy           = (state_r != S_IDLE);
    assign in_ready       = (state_r == S_WAIT_IN);
    assign wmem_rd_en     = rd_en_s;
    assign wmem_addr      = rd_en_s ? idx_r[ADDR_W-1:0] : {ADDR_W{1'b0}};
    // Row data arrives the cycle after the read strobe, so it is forwarded straight through in LOAD.
    assign pe_weight      = (state_r == S_LOAD) ? wmem_rdata : {(N_PE*WEIGHT_W){1'b0}};
    assign pe_weight_w_en = (state_r == S_LOAD);
    assign pe_accum_en    = (state_r == S_ACCUM);
    assign pe_spike_done  = (state_r == S_FIRE);
    assign out_spikes     = out_spikes_r;
    assign out_valid      = out_valid_r;
    assign done           = done_r;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && (num_steps != {STEP_W{1'b0}})) state_nxt_s = S_WAIT_IN;
                else                                         state_nxt_s = S_IDLE;
            end
            S_WAIT_IN: begin
                if (in_valid) state_nxt_s = S_SCAN;
                else          state_nxt_s = S_WAIT_IN;
            end
            S_SCAN: begin
                if (idx_end_s)      state_nxt_s = S_FIRE;
                else if (cur_bit_s) state_nxt_s = S_LOAD;
                else                state_nxt_s = S_SCAN;
            end
            S_LOAD:  state_nxt_s = S_ACCUM;
            S_ACCUM: state_nxt_s = S_SCAN;
            S_FIRE:  state_nxt_s = S_CAPTURE;
            S_CAPTURE: begin
                if (out_ready && last_step_s) state_nxt_s = S_IDLE;
                else if (out_ready)           state_nxt_s = S_WAIT_IN;
                else                          state_nxt_s = S_CAPTURE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Step counters, spike latch, captured result and done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_r        <= {IDX_W{1'b0}};
            spike_reg_r  <= {N_IN{1'b0}};
            step_cnt_r   <= {STEP_W{1'b0}};
            num_steps_r  <= {STEP_W{1'b0}};
            out_spikes_r <= {N_PE{1'b0}};
            out_valid_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        num_steps_r <= num_steps;
                        step_cnt_r  <= {STEP_W{1'b0}};
                        done_r      <= (num_steps == {STEP_W{1'b0}});
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        spike_reg_r <= in_spikes;
                        idx_r       <= {IDX_W{1'b0}};
                    end
                end
                S_SCAN: begin
                    if (!idx_end_s && !cur_bit_s) idx_r <= idx_r + IDX_ONE;
                end
                S_ACCUM: idx_r <= idx_r + IDX_ONE;
                S_FIRE: begin
                    out_spikes_r <= pe_spike;
                    out_valid_r  <= 1'b1;
                end
                S_CAPTURE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        step_cnt_r  <= step_cnt_r + STEP_ONE;
                        done_r      <= last_step_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_layer_sched.sv
// Scoreboard bench for pe_layer_sched: random spike vectors against a sum-and-threshold
// PE reference, with a weight memory and PE array modelled around the DUT.
`timescale 1ns/1ps
module tb_pe_layer_sched;
    localparam int N_PE = 4, N_IN = 8, WEIGHT_W = 8, STEP_W = 8, THR = 300;

    logic clock = 1'b0;
    logic reset_n, start, in_valid, in_ready, busy, done, out_valid, out_ready;
    logic [STEP_W-1:0] num_steps;
    logic [N_IN-1:0] in_spikes;
    logic wmem_rd_en, pe_weight_w_en, pe_accum_en, pe_spike_done;
    logic [2:0] wmem_addr;
    logic [31:0] wmem_rdata, pe_weight;
    logic [N_PE-1:0] pe_spike, out_spikes;

    logic [31:0] mem [N_IN];
    int acc [N_PE];
    logic [WEIGHT_W-1:0] wl [N_PE];

    typedef struct packed { logic [7:0] sp; logic [3:0] want; } exp_t;
    exp_t exp_q[$];
    int run_q[$];

    int n_cmp = 0, n_fail = 0;
    int drv_cmp = 0, drv_fail = 0, drv_cmp_seen = 0, drv_fail_seen = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pe_layer_sched #(.N_PE(N_PE), .N_IN(N_IN), .WEIGHT_W(WEIGHT_W), .STEP_W(STEP_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .num_steps(num_steps),
        .busy(busy), .done(done), .in_spikes(in_spikes), .in_valid(in_valid),
        .in_ready(in_ready), .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr),
        .wmem_rdata(wmem_rdata), .pe_weight(pe_weight), .pe_weight_w_en(pe_weight_w_en),
        .pe_accum_en(pe_accum_en), .pe_spike_done(pe_spike_done), .pe_spike(pe_spike),
        .out_spikes(out_spikes), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Weight memory: one-cycle read latency, garbage when not read.
    always @(posedge clock) wmem_rdata <= wmem_rd_en ? mem[wmem_addr] : $urandom();

    // PE array: latch weight, accumulate, clear at end of step.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_PE; k++) begin acc[k] <= 0; wl[k] <= '0; end
        end else begin
            for (int k = 0; k < N_PE; k++) begin
                if (pe_weight_w_en) wl[k] <= pe_weight[k*8 +: 8];
                if (pe_accum_en) acc[k] <= acc[k] + int'(wl[k]);
                if (pe_spike_done) acc[k] <= 0;
            end
        end
    end

    always_comb begin
        pe_spike = '0;
        for (int k = 0; k < N_PE; k++) pe_spike[k] = (acc[k] >= THR);
    end

    function automatic logic [3:0] ref_out(input logic [7:0] sp);
        logic [3:0] r;
        int s;
        r = '0;
        for (int k = 0; k < N_PE; k++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++) if (sp[i]) s += int'(mem[i][k*8 +: 8]);
            r[k] = (s >= THR);
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    int accept_cyc = 0, done_due = -1, steps_left = 0, n_wen = 0, n_acc = 0;
    logic ov_prev = 1'b0, ov_acc_prev = 1'b0, prev_rd = 1'b0;
    logic [3:0] held = '0;
    logic [2:0] last_addr = '0;
    logic [2:0] seen_addr[$];

    always @(negedge clock) begin
        exp_t e;
        int p, j;
        logic ok;
        n_cmp  += drv_cmp - drv_cmp_seen;
        n_fail += drv_fail - drv_fail_seen;
        drv_cmp_seen = drv_cmp;
        drv_fail_seen = drv_fail;
        if (!reset_n) begin
            exp_q.delete(); run_q.delete(); seen_addr.delete();
            done_due = -1; steps_left = 0; ov_prev = 1'b0; ov_acc_prev = 1'b0; prev_rd = 1'b0;
        end else begin
            if (wmem_rd_en | pe_weight_w_en | pe_accum_en | pe_spike_done)
                chk("strobe_excl", $countones({wmem_rd_en, pe_weight_w_en, pe_accum_en, pe_spike_done}), 1);
            chk("pe_weight", pe_weight, pe_weight_w_en ? mem[last_addr] : 32'h0);
            if (pe_weight_w_en) chk("rd_before_wen", prev_rd, 1);
            if (wmem_rd_en) begin last_addr = wmem_addr; seen_addr.push_back(wmem_addr); end
            prev_rd = wmem_rd_en;
            if (pe_weight_w_en) n_wen++;
            if (pe_accum_en) n_acc++;
            if (in_ready) chk("in_ready_excl", {out_valid, !busy}, 2'b00);
            if (in_valid && in_ready) begin
                accept_cyc = cyc + 1; seen_addr.delete(); n_wen = 0; n_acc = 0;
            end
            if (ov_acc_prev) chk("out_valid_drop", out_valid, 0);
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) chk("exp_avail", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    p = $countones(e.sp);
                    chk("out_spikes", out_spikes, e.want);
                    chk("latency", cyc - accept_cyc, N_IN + 2*p + 2);
                    chk("w_en_count", n_wen, p);
                    chk("accum_count", n_acc, p);
                    ok = (seen_addr.size() == p);
                    j = 0;
                    for (int i = 0; i < N_IN; i++) if (e.sp[i]) begin
                        if (j >= seen_addr.size() || seen_addr[j] != 3'(i)) ok = 1'b0;
                        j++;
                    end
                    chk("addr_seq", ok, 1);
                end
                held = out_spikes;
            end
            if (out_valid && ov_prev) chk("out_hold", out_spikes, held);
            ov_acc_prev = out_valid && out_ready;
            if (done || cyc == done_due) begin
                chk("done", done, cyc == done_due);
                if (done) chk("busy_at_done", busy, 0);
            end
            if (out_valid && out_ready) begin
                steps_left--;
                if (steps_left == 0) done_due = cyc + 1;
            end
            if (start && !busy) begin
                if (run_q.size() == 0) chk("run_avail", 0, 1);
                else begin
                    steps_left = run_q.pop_front();
                    if (steps_left == 0) done_due = cyc + 1;
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic drv_chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        drv_cmp++;
        if (act !== want) begin
            drv_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic check_zero(input string nm);
        drv_chk(nm, {busy, done, in_ready, wmem_rd_en, wmem_addr, pe_weight, pe_weight_w_en,
                     pe_accum_en, pe_spike_done, out_spikes, out_valid}, 64'h0);
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; num_steps = 8'(n); run_q.push_back(n);
        tick();
        start = 1'b0;
        if (n == 0) drv_chk("zero_run_busy", busy, 0);
    endtask

    task automatic send_in(input logic [7:0] sp, output logic ok);
        exp_t e;
        int t = 0;
        in_spikes = sp; in_valid = 1'b1;
        while (!in_ready && t < 100) begin tick(); t++; end
        ok = in_ready;
        if (!ok) drv_chk("in_ready_timeout", 0, 1);
        else begin
            e.sp = sp; e.want = ref_out(sp);
            exp_q.push_back(e);
            tick();
        end
        in_valid = 1'b0; in_spikes = 8'($urandom());
    endtask

    task automatic do_step(input logic [7:0] sp, input int hold);
        logic ok;
        int t = 0;
        send_in(sp, ok);
        if (ok) begin
            while (!out_valid && t < 200) begin tick(); t++; end
            if (!out_valid) drv_chk("out_valid_timeout", 0, 1);
            else begin
                repeat (hold) tick();
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 100) begin tick(); t++; end
        if (!done) drv_chk("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        logic ok;
        int n, t;
        reset_n = 1'b0; start = 1'b0; num_steps = '0; in_spikes = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N_IN; i++) mem[i] = $urandom();
        mem[0] = 32'h0A0A0A0A;
        repeat (3) @(posedge clock);
        #1 check_zero("reset_hold");
        reset_n = 1'b1;
        tick();
        check_zero("reset_state");

        do_start(1); do_step(8'h01, 0); wait_done();
        do_start(1); do_step(8'h00, 0); wait_done();
        do_start(1); do_step(8'hA5, 1); wait_done();

        do_start(3);
        start = 1'b1; num_steps = 8'd0; tick(); start = 1'b0;
        do_step(8'($urandom()), 5);
        do_step(8'($urandom()), $urandom_range(0, 2));
        do_step(8'($urandom()), 0);
        wait_done();

        do_start(0); wait_done();

        // Reset in the middle of an accumulate; the run must vanish without done.
        do_start(2);
        send_in(8'hFF, ok);
        t = 0;
        while (!pe_accum_en && t < 50) begin tick(); t++; end
        if (!pe_accum_en) drv_chk("accum_timeout", 0, 1);
        #1 reset_n = 1'b0;
        #1 check_zero("reset_async");
        @(negedge clock); #1 reset_n = 1'b1;
        tick();
        check_zero("post_reset");
        repeat (3) tick();

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            do_start(n);
            for (int s = 0; s < n; s++) do_step(8'($urandom()), $urandom_range(0, 3));
            wait_done();
        end

        do_start(255);
        for (int s = 0; s < 255; s++) do_step(8'($urandom()), 0);
        wait_done();

        repeat (3) tick();
        @(negedge clock); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
